// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction controller: sequences address reception, ACK/NACK
// generation and byte transmission from decoder and SCL timer event pulses.
module i2c_slave_ctrl (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       address_match,
    input  logic       rw_mode,
    input  logic       byte_received,
    input  logic       ack_prep,
    input  logic       check_ack,
    input  logic       ack_done,
    input  logic       sda_in,
    input  logic       tx_fifo_empty,
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       read_enable,
    output logic       load_data,
    output logic [1:0] sda_mode,
    output logic [7:0] tx_count
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        RX_ADDR    = 4'd1,
        ADDR_CHECK = 4'd2,
        ACK_PREP   = 4'd3,
        ACK_DRIVE  = 4'd4,
        NACK_PREP  = 4'd5,
        NACK_DRIVE = 4'd6,
        LOAD       = 4'd7,
        TX_BYTE    = 4'd8,
        CHECK_MACK = 4'd9,
        MACK_DONE  = 4'd10
    } state_t;

    state_t state, next_state;
    logic   nack_flag, nack_flag_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            nack_flag <= 1'b0;
            tx_count  <= 8'd0;
        end else begin
            state     <= next_state;
            nack_flag <= nack_flag_next;
            if (start_found)
                tx_count <= 8'd0;
            else if (state == LOAD && !stop_found && tx_count != 8'hFF)
                tx_count <= tx_count + 8'd1;
        end
    end

    always_comb begin
        next_state     = state;
        nack_flag_next = 1'b0;
        case (state)
            IDLE:       if (start_found) next_state = RX_ADDR;
            RX_ADDR:    if (byte_received) next_state = ADDR_CHECK;
            ADDR_CHECK: next_state = (address_match && rw_mode && !tx_fifo_empty)
                                     ? ACK_PREP : NACK_PREP;
            ACK_PREP:   if (ack_prep) next_state = ACK_DRIVE;
            ACK_DRIVE:  if (ack_done) next_state = LOAD;
            NACK_PREP:  if (ack_prep) next_state = NACK_DRIVE;
            NACK_DRIVE: if (ack_done) next_state = IDLE;
            LOAD:       next_state = TX_BYTE;
            TX_BYTE:    if (ack_prep) next_state = CHECK_MACK;
            CHECK_MACK: begin
                // A master NACK is remembered so the bus is released until the ACK bit ends
                if (nack_flag) begin
                    if (ack_done) next_state = IDLE;
                    else          nack_flag_next = 1'b1;
                end else if (check_ack) begin
                    if (sda_in) nack_flag_next = 1'b1;
                    else        next_state = MACK_DONE;
                end
            end
            MACK_DONE:  if (ack_done) next_state = LOAD;
            default:    next_state = IDLE;
        endcase
        if (start_found) begin
            next_state     = RX_ADDR;
            nack_flag_next = 1'b0;
        end
        if (stop_found) begin
            next_state     = IDLE;
            nack_flag_next = 1'b0;
        end
    end

    always_comb begin
        rx_enable   = 1'b0;
        tx_enable   = 1'b0;
        read_enable = 1'b0;
        load_data   = 1'b0;
        sda_mode    = 2'b00;
        case (state)
            RX_ADDR:    rx_enable = 1'b1;
            ACK_DRIVE:  sda_mode = 2'b01;
            NACK_DRIVE: sda_mode = 2'b10;
            LOAD: begin
                read_enable = 1'b1;
                load_data   = 1'b1;
            end
            TX_BYTE: begin
                tx_enable = 1'b1;
                sda_mode  = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Scoreboard bench for i2c_slave_ctrl: a transaction-level script predicts the
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       n_rst, start_found, stop_found, address_match, rw_mode;
    logic       byte_received, ack_prep, check_ack, ack_done, sda_in, tx_fifo_empty;
    logic       rx_enable, tx_enable, read_enable, load_data;
    logic [1:0] sda_mode;
    logic [7:0] tx_count;

    localparam int P_NONE = 0, P_BR = 1, P_AP = 2, P_CA = 3, P_AD = 4, P_START = 5, P_STOP = 6;

    logic [13:0] exp_q[$];
    int tests_run = 0, tests_failed = 0;
    int model_count = 0;
    int step_idx = 0, abort_at = -1, force_kind = -1, max_gap = 3;
    logic aborted = 1'b0;
    string phase_name = "reset";

    i2c_slave_ctrl dut (
        .clk(clk), .n_rst(n_rst), .start_found(start_found), .stop_found(stop_found),
        .address_match(address_match), .rw_mode(rw_mode), .byte_received(byte_received),
        .ack_prep(ack_prep), .check_ack(check_ack), .ack_done(ack_done), .sda_in(sda_in),
        .tx_fifo_empty(tx_fifo_empty), .rx_enable(rx_enable), .tx_enable(tx_enable),
        .read_enable(read_enable), .load_data(load_data), .sda_mode(sda_mode), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ev(input logic rx, input logic tx, input logic re,
                                       input logic ld, input logic [1:0] mode, input int cnt);
        logic [31:0] c;
        c = cnt;
        return {rx, tx, re, ld, mode, c[7:0]};
    endfunction

    function automatic logic [13:0] zero_e(input int c); return ev(0, 0, 0, 0, 2'b00, c); endfunction
    function automatic logic [13:0] rx_e(input int c);   return ev(1, 0, 0, 0, 2'b00, c); endfunction
    function automatic logic [13:0] ack_e(input int c);  return ev(0, 0, 0, 0, 2'b01, c); endfunction
    function automatic logic [13:0] nack_e(input int c); return ev(0, 0, 0, 0, 2'b10, c); endfunction
    function automatic logic [13:0] load_e(input int c); return ev(0, 0, 1, 1, 2'b00, c); endfunction
    function automatic logic [13:0] tx_e(input int c);   return ev(0, 1, 0, 0, 2'b11, c); endfunction
    function automatic int sat_inc(input int c); return (c >= 255) ? 255 : c + 1; endfunction

    function automatic int noise(input int awaited);
        int n;
        do n = $urandom_range(0, 4); while (n == awaited);
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {rx_enable, tx_enable, read_enable, load_data, sda_mode, tx_count};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got rx=%b tx=%b re=%b ld=%b mode=%b cnt=%0d, expected rx=%b tx=%b re=%b ld=%b mode=%b cnt=%0d",
                     name, act[13], act[12], act[11], act[10], act[9:8], act[7:0],
                     exp[13], exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(phase_name, exp_q.pop_front());
    end

    // One clock of stimulus; optionally replaced by a random START/STOP abort
    task automatic applyStimulus(input int pulse, input logic sda, input logic keep_addr,
                                 input logic [13:0] exp_after, input int new_count);
        logic [13:0] e;
        int kind;
        if (aborted) return;
        byte_received = (pulse == P_BR);
        ack_prep      = (pulse == P_AP);
        check_ack     = (pulse == P_CA);
        ack_done      = (pulse == P_AD);
        start_found   = (pulse == P_START);
        stop_found    = (pulse == P_STOP);
        sda_in        = sda;
        if (!keep_addr) begin
            address_match = 1'($urandom);
            rw_mode       = 1'($urandom);
            tx_fifo_empty = 1'($urandom);
        end
        e = exp_after;
        if (abort_at >= 0 && step_idx == abort_at) begin
            kind = (force_kind >= 0) ? force_kind : $urandom_range(0, 2);
            start_found = (kind != 0);
            stop_found  = (kind != 1);
            if (start_found) model_count = 0;
            e = stop_found ? zero_e(model_count) : rx_e(0);
            aborted = 1'b1;
        end else begin
            model_count = new_count;
        end
        step_idx++;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        {byte_received, ack_prep, check_ack, ack_done, start_found, stop_found} = '0;
    endtask

    task automatic waitPulse(input int pulse, input logic sda, input logic [13:0] e_during,
                             input logic [13:0] e_after, input int cnt_after);
        int gap;
        gap = $urandom_range(0, max_gap);
        for (int i = 0; i < gap; i++)
            applyStimulus(noise(pulse), 1'($urandom), 1'b0, e_during, model_count);
        applyStimulus(pulse, sda, 1'b0, e_after, cnt_after);
    endtask

    task automatic runTransaction(input string name, input logic am, input logic rw, input logic fe,
                                  input int nbytes, input int abort_step, input int kind);
        phase_name = name;
        aborted = 1'b0; step_idx = 0; abort_at = abort_step; force_kind = kind;
        applyStimulus(P_START, 1'b0, 1'b0, rx_e(0), 0);
        waitPulse(P_BR, 1'b0, rx_e(model_count), zero_e(model_count), model_count);
        address_match = am; rw_mode = rw; tx_fifo_empty = fe;
        applyStimulus(noise(P_NONE), 1'($urandom), 1'b1, zero_e(model_count), model_count);
        if (!(am && rw && !fe)) begin
            waitPulse(P_AP, 1'b0, zero_e(model_count), nack_e(model_count), model_count);
            waitPulse(P_AD, 1'b0, nack_e(model_count), zero_e(model_count), model_count);
        end else begin
            waitPulse(P_AP, 1'b0, zero_e(model_count), ack_e(model_count), model_count);
            waitPulse(P_AD, 1'b0, ack_e(model_count), load_e(model_count), model_count);
            for (int b = 0; b < nbytes; b++) begin
                applyStimulus(noise(P_NONE), 1'($urandom), 1'b0,
                              tx_e(sat_inc(model_count)), sat_inc(model_count));
                waitPulse(P_AP, 1'b0, tx_e(model_count), zero_e(model_count), model_count);
                if (b < nbytes - 1) begin
                    waitPulse(P_CA, 1'b0, zero_e(model_count), zero_e(model_count), model_count);
                    waitPulse(P_AD, 1'b0, zero_e(model_count), load_e(model_count), model_count);
                end else begin
                    waitPulse(P_CA, 1'b1, zero_e(model_count), zero_e(model_count), model_count);
                    waitPulse(P_AD, 1'b0, zero_e(model_count), zero_e(model_count), model_count);
                end
            end
        end
        // Return to a known idle bus, then idle with ignored timer noise
        aborted = 1'b0; abort_at = -1;
        applyStimulus(P_STOP, 1'b0, 1'b0, zero_e(model_count), model_count);
        for (int i = 0; i < $urandom_range(0, 2); i++)
            applyStimulus(noise(P_NONE), 1'($urandom), 1'b0, zero_e(model_count), model_count);
    endtask

    initial begin
        n_rst = 1'b0;
        {start_found, stop_found, address_match, rw_mode, byte_received} = '0;
        {ack_prep, check_ack, ack_done, sda_in, tx_fifo_empty} = '0;
        #8;
        checkOutput("reset_state", zero_e(0));
        #9 n_rst = 1'b1;

        max_gap = 0;
        runTransaction("write_nack", 1'b1, 1'b0, 1'b0, 0, -1, -1);
        runTransaction("read_ack_then_nack", 1'b1, 1'b1, 1'b0, 2, -1, -1);
        runTransaction("empty_fifo_nack", 1'b1, 1'b1, 1'b1, 0, -1, -1);
        runTransaction("no_addr_match", 1'b0, 1'b1, 1'b0, 0, -1, -1);
        runTransaction("start_stop_in_tx", 1'b1, 1'b1, 1'b0, 3, 6, 2);
        runTransaction("restart_in_check_mack", 1'b1, 1'b1, 1'b0, 3, 7, 1);
        runTransaction("stop_in_load", 1'b1, 1'b1, 1'b0, 3, 5, 0);
        runTransaction("count_saturation", 1'b1, 1'b1, 1'b0, 258, -1, -1);

        // Asynchronous reset in the middle of TX_BYTE
        phase_name = "pre_reset_tx"; aborted = 1'b0; abort_at = -1;
        applyStimulus(P_START, 1'b0, 1'b0, rx_e(0), 0);
        applyStimulus(P_BR, 1'b0, 1'b0, zero_e(0), 0);
        address_match = 1'b1; rw_mode = 1'b1; tx_fifo_empty = 1'b0;
        applyStimulus(P_NONE, 1'b0, 1'b1, zero_e(0), 0);
        applyStimulus(P_AP, 1'b0, 1'b0, ack_e(0), 0);
        applyStimulus(P_AD, 1'b0, 1'b0, load_e(0), 0);
        applyStimulus(P_NONE, 1'b0, 1'b0, tx_e(1), 1);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1 checkOutput("async_reset_mid_tx", zero_e(0));
        model_count = 0;
        @(posedge clk);
        #3 n_rst = 1'b1;
        phase_name = "post_reset_idle";
        applyStimulus(noise(P_NONE), 1'b0, 1'b0, zero_e(0), 0);

        max_gap = 3;
        for (int t = 0; t < 40; t++) begin
            runTransaction($sformatf("random_txn%0d", t),
                           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 4) == 0), $urandom_range(1, 5),
                           ($urandom_range(0, 2) == 0) ? $urandom_range(0, 25) : -1, -1);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
